// File: rtl/usb_rx_nrzi_unstuff.sv
// USB receive front end: NRZI decode, bit-unstuffing with violation flag, LSB-first byte assembly.
// All outputs are registered, 1 cycle after the strobe; there is no backpressure, one bit is accepted per strobe.
module usb_rx_nrzi_unstuff (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_sync,
  input  logic       shift_enable,
  input  logic       init,
  output logic       d_unstuffed,
  output logic       final_enable,
  output logic       stuff_err,
  output logic [7:0] rx_byte,
  output logic       byte_ready
);

  logic       prev_line_q, prev_line_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       dout_q, dout_d;
  logic       fe_q, fe_d;
  logic       br_q, br_d;
  logic       err_q, err_d;
  logic       bit_w;

  // No line transition decodes as 1, a transition as 0.
  assign bit_w = ~(d_plus_sync ^ prev_line_q);

  always_comb begin
    prev_line_d = prev_line_q;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_byte_d   = rx_byte_q;
    dout_d      = dout_q;
    err_d       = err_q;
    fe_d        = 1'b0;
    br_d        = 1'b0;

    if (shift_enable) begin
      prev_line_d = d_plus_sync;
    end

    if (init) begin
      ones_cnt_d = 3'd0;
      bit_cnt_d  = 3'd0;
      shreg_d    = 8'h00;
      err_d      = 1'b0;
    end else if (shift_enable) begin
      if (ones_cnt_q == 3'd6) begin
        // Seventh bit after six ones is a stuff bit; a 1 here is a violation.
        ones_cnt_d = 3'd0;
        if (bit_w) begin
          err_d = 1'b1;
        end
      end else begin
        fe_d       = 1'b1;
        dout_d     = bit_w;
        ones_cnt_d = bit_w ? ones_cnt_q + 3'd1 : 3'd0;
        shreg_d    = {bit_w, shreg_q[7:1]};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_d = {bit_w, shreg_q[7:1]};
          br_d      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_line_q <= 1'b1;
      ones_cnt_q  <= 3'd0;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      rx_byte_q   <= 8'h00;
      dout_q      <= 1'b0;
      fe_q        <= 1'b0;
      br_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_line_q <= prev_line_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_byte_q   <= rx_byte_d;
      dout_q      <= dout_d;
      fe_q        <= fe_d;
      br_q        <= br_d;
      err_q       <= err_d;
    end
  end

  assign d_unstuffed  = dout_q;
  assign final_enable = fe_q;
  assign stuff_err    = err_q;
  assign rx_byte      = rx_byte_q;
  assign byte_ready   = br_q;

endmodule
